// File: rtl/sync_fifo_asym.sv
// Single-clock FIFO with independent write and read widths.
// Storage and occupancy are kept in units of the narrower width, so upsizing
// and downsizing share one datapath. The low unit of every word is the one
// that is first in time on both the write and the read side.
module sync_fifo_asym #(
   parameter int WRITE_WIDTH = 32,
   parameter int READ_WIDTH  = 64,
   parameter int WRITE_DEPTH = 8,
   parameter int ALMOST_WR   = 2,
   parameter int ALMOST_RD   = 2,
   parameter int FWFT        = 0
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               wr_en,
   input  logic [WRITE_WIDTH-1:0]                             din,
   output logic                                               full,
   output logic                                               almost_full,
   output logic                                               wr_ack,
   output logic                                               overflow,
   output logic [$clog2(WRITE_DEPTH):0]                       wr_count,
   input  logic                                               rd_en,
   output logic [READ_WIDTH-1:0]                              dout,
   output logic                                               valid,
   output logic                                               underflow,
   output logic                                               empty,
   output logic                                               almost_empty,
   output logic [$clog2(WRITE_DEPTH*WRITE_WIDTH/READ_WIDTH):0] rd_count
);

   localparam int MIN_W    = (WRITE_WIDTH < READ_WIDTH) ? WRITE_WIDTH : READ_WIDTH;
   localparam int MAX_W    = (WRITE_WIDTH < READ_WIDTH) ? READ_WIDTH : WRITE_WIDTH;
   localparam int WU       = WRITE_WIDTH / MIN_W;
   localparam int RU       = READ_WIDTH / MIN_W;
   localparam int CAP      = WRITE_DEPTH * WU;
   localparam int RD_DEPTH = WRITE_DEPTH * WRITE_WIDTH / READ_WIDTH;
   localparam int PTR_W    = $clog2(CAP);
   localparam int UW       = PTR_W + 1;
   localparam int WCW      = $clog2(WRITE_DEPTH) + 1;
   localparam int RCW      = $clog2(RD_DEPTH) + 1;
   localparam int WU_SH    = $clog2(WU);
   localparam int RU_SH    = $clog2(RU);

   localparam logic [UW-1:0]    CAP_U = UW'(CAP);
   localparam logic [UW-1:0]    WU_U  = UW'(WU);
   localparam logic [UW-1:0]    RU_U  = UW'(RU);
   localparam logic [PTR_W-1:0] WU_P  = PTR_W'(WU);
   localparam logic [PTR_W-1:0] RU_P  = PTR_W'(RU);

   localparam bit WW_OK = (WRITE_WIDTH > 0) && ((WRITE_WIDTH & (WRITE_WIDTH - 1)) == 0);
   localparam bit RW_OK = (READ_WIDTH > 0) && ((READ_WIDTH & (READ_WIDTH - 1)) == 0);
   localparam bit WD_OK = (WRITE_DEPTH > 0) && ((WRITE_DEPTH & (WRITE_DEPTH - 1)) == 0);

   // Reject parameter sets the unit-based datapath cannot represent.
   if (!WW_OK) begin : g_err_ww
      $error("sync_fifo_asym: WRITE_WIDTH must be a power of two");
   end
   if (!RW_OK) begin : g_err_rw
      $error("sync_fifo_asym: READ_WIDTH must be a power of two");
   end
   if (!WD_OK) begin : g_err_wd
      $error("sync_fifo_asym: WRITE_DEPTH must be a power of two");
   end
   if (RD_DEPTH < 2) begin : g_err_rd
      $error("sync_fifo_asym: read depth must be at least 2");
   end
   if (MAX_W / MIN_W > 64) begin : g_err_ratio
      $error("sync_fifo_asym: width ratio must not exceed 64");
   end

   logic [MIN_W-1:0]      mem [CAP];
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [UW-1:0]         used_reg;
   logic [UW-1:0]         used_next;
   logic [READ_WIDTH-1:0] head;
   logic                  wr_acc;
   logic                  rd_acc;

   // Flags are derived only from the registered unit count.
   assign full         = (CAP_U - used_reg) < WU_U;
   assign empty        = used_reg < RU_U;
   assign wr_count     = WCW'(used_reg >> WU_SH);
   assign rd_count     = RCW'(used_reg >> RU_SH);
   assign almost_full  = int'(wr_count) >= (WRITE_DEPTH - ALMOST_WR);
   assign almost_empty = int'(rd_count) <= ALMOST_RD;

   assign wr_acc = wr_en & ~full;
   assign rd_acc = rd_en & ~empty;

   // Occupancy update; a simultaneous read and write nets out in one step.
   always_comb begin
      used_next = used_reg;
      case ({wr_acc, rd_acc})
         2'b10:   used_next = used_reg + WU_U;
         2'b01:   used_next = used_reg - RU_U;
         2'b11:   used_next = used_reg + WU_U - RU_U;
         default: used_next = used_reg;
      endcase
   end

   // Pointers and occupancy; pointers move in whole words and wrap modulo CAP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         used_reg   <= '0;
      end else begin
         used_reg <= used_next;
         if (wr_acc) wr_ptr_reg <= wr_ptr_reg + WU_P;
         if (rd_acc) rd_ptr_reg <= rd_ptr_reg + RU_P;
      end
   end

   // Storage write: slice i of the write word goes to unit address wr_ptr+i.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int i = 0; i < WU; i++) begin
            mem[wr_ptr_reg + PTR_W'(i)] <= din[i*MIN_W +: MIN_W];
         end
      end
   end

   // Head read word: unit rd_ptr+gi lands in slice gi, oldest unit lowest.
   for (genvar gi = 0; gi < RU; gi++) begin : g_head
      localparam logic [PTR_W-1:0] OFF = PTR_W'(gi);
      assign head[gi*MIN_W +: MIN_W] = mem[rd_ptr_reg + OFF];
   end

   // Write/read status pulses reflect the previous cycle's decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ack    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         wr_ack    <= wr_acc;
         overflow  <= wr_en & full;
         underflow <= rd_en & empty;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; nothing is shown while empty so stale
      // storage never leaks out.
      assign dout  = empty ? '0 : head;
      assign valid = ~empty;
   end else begin : g_std
      logic [READ_WIDTH-1:0] dout_reg;
      logic                  valid_reg;

      // Registered read: capture the head word on an accepted read, else hold.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dout_reg  <= '0;
            valid_reg <= 1'b0;
         end else begin
            valid_reg <= rd_acc;
            if (rd_acc) dout_reg <= head;
         end
      end

      assign dout  = dout_reg;
      assign valid = valid_reg;
   end

endmodule

// File: tb/tb_sync_fifo_asym.sv
// Directed bench for sync_fifo_asym: a default 32->64 standard-mode instance
// and a 64->16 first-word-fall-through instance share clock and reset.
module tb_sync_fifo_asym;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   // Instance A: defaults (32 -> 64, depth 8, standard read)
   logic        a_wr_en, a_rd_en;
   logic [31:0] a_din;
   logic        a_full, a_almost_full, a_wr_ack, a_overflow;
   logic [3:0]  a_wr_count;
   logic [63:0] a_dout;
   logic        a_valid, a_underflow, a_empty, a_almost_empty;
   logic [2:0]  a_rd_count;

   // Instance B: 64 -> 16, depth 4, FWFT
   logic        b_wr_en, b_rd_en;
   logic [63:0] b_din;
   logic        b_full, b_almost_full, b_wr_ack, b_overflow;
   logic [2:0]  b_wr_count;
   logic [15:0] b_dout;
   logic        b_valid, b_underflow, b_empty, b_almost_empty;
   logic [4:0]  b_rd_count;

   sync_fifo_asym dut_a (
      .clk(clk), .rst(rst),
      .wr_en(a_wr_en), .din(a_din), .full(a_full), .almost_full(a_almost_full),
      .wr_ack(a_wr_ack), .overflow(a_overflow), .wr_count(a_wr_count),
      .rd_en(a_rd_en), .dout(a_dout), .valid(a_valid), .underflow(a_underflow),
      .empty(a_empty), .almost_empty(a_almost_empty), .rd_count(a_rd_count)
   );

   sync_fifo_asym #(
      .WRITE_WIDTH(64), .READ_WIDTH(16), .WRITE_DEPTH(4),
      .ALMOST_WR(1), .ALMOST_RD(2), .FWFT(1)
   ) dut_b (
      .clk(clk), .rst(rst),
      .wr_en(b_wr_en), .din(b_din), .full(b_full), .almost_full(b_almost_full),
      .wr_ack(b_wr_ack), .overflow(b_overflow), .wr_count(b_wr_count),
      .rd_en(b_rd_en), .dout(b_dout), .valid(b_valid), .underflow(b_underflow),
      .empty(b_empty), .almost_empty(b_almost_empty), .rd_count(b_rd_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        w_b, r_b, exp_rd, exp_wr;
      logic [63:0] exp_d;
      logic [31:0] d_saved;
      logic [31:0] q[$];

      a_wr_en = 0; a_rd_en = 0; a_din = '0;
      b_wr_en = 0; b_rd_en = 0; b_din = '0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_empty", a_empty, 1);
      chk("rst_aempty", a_almost_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_afull", a_almost_full, 0);
      chk("rst_wrcnt", a_wr_count, 0);
      chk("rst_rdcnt", a_rd_count, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_b_empty", b_empty, 1);
      chk("rst_b_dout", b_dout, 0);
      $display("reset state checked");
      rst = 0;

      // Upsizing: two writes form one read word, first write in the low half
      a_wr_en = 1; a_din = 32'h1111_1111;
      tick;
      chk("w1_ack", a_wr_ack, 1);
      chk("w1_empty", a_empty, 1);
      chk("w1_wrcnt", a_wr_count, 1);
      chk("w1_rdcnt", a_rd_count, 0);
      a_din = 32'h2222_2222;
      tick;
      a_wr_en = 0;
      chk("w2_empty", a_empty, 0);
      chk("w2_rdcnt", a_rd_count, 1);
      a_rd_en = 1;
      tick;
      a_rd_en = 0;
      chk("r1_valid", a_valid, 1);
      chk("r1_dout", a_dout, 64'h2222_2222_1111_1111);
      chk("r1_empty", a_empty, 1);
      $display("upsize read dout=%h valid=%0b", a_dout, a_valid);
      tick;
      chk("r1_valid_pulse", a_valid, 0);
      chk("r1_dout_hold", a_dout, 64'h2222_2222_1111_1111);

      // Read on empty
      a_rd_en = 1;
      tick;
      a_rd_en = 0;
      chk("uf_pulse", a_underflow, 1);
      chk("uf_valid", a_valid, 0);
      chk("uf_dout", a_dout, 64'h2222_2222_1111_1111);
      $display("underflow=%0b on empty read", a_underflow);
      tick;
      chk("uf_clear", a_underflow, 0);

      // Fill to full
      for (int i = 0; i < 8; i++) begin
         a_wr_en = 1; a_din = 32'hA000_0000 + 32'(i);
         tick;
         if (i == 4) chk("fill5_afull", a_almost_full, 0);
         if (i == 5) chk("fill6_afull", a_almost_full, 1);
      end
      chk("fill_full", a_full, 1);
      chk("fill_wrcnt", a_wr_count, 8);
      chk("fill_rdcnt", a_rd_count, 4);
      $display("filled wr_count=%0d rd_count=%0d full=%0b", a_wr_count, a_rd_count, a_full);

      // Write while full is dropped
      a_din = 32'hDEAD_BEEF;
      tick;
      chk("of_pulse", a_overflow, 1);
      chk("of_noack", a_wr_ack, 0);
      chk("of_wrcnt", a_wr_count, 8);

      // Read and write together while full: read taken, write dropped
      a_din = 32'hBAD0_BAD0; a_rd_en = 1;
      tick;
      chk("rwf_valid", a_valid, 1);
      chk("rwf_dout", a_dout, 64'hA000_0001_A000_0000);
      chk("rwf_of", a_overflow, 1);
      chk("rwf_wrcnt", a_wr_count, 6);
      chk("rwf_rdcnt", a_rd_count, 3);

      // Read and write together with room: both taken
      a_din = 32'hB0B0_B0B0;
      tick;
      a_wr_en = 0;
      chk("rw_dout", a_dout, 64'hA000_0003_A000_0002);
      chk("rw_ack", a_wr_ack, 1);
      chk("rw_wrcnt", a_wr_count, 5);
      chk("rw_rdcnt", a_rd_count, 2);
      $display("simultaneous rd/wr wr_count=%0d rd_count=%0d", a_wr_count, a_rd_count);

      // Drain: dropped words never appear
      tick;
      chk("dr1_dout", a_dout, 64'hA000_0005_A000_0004);
      tick;
      a_rd_en = 0;
      chk("dr2_dout", a_dout, 64'hA000_0007_A000_0006);
      chk("dr_empty", a_empty, 1);
      chk("dr_wrcnt", a_wr_count, 1);
      chk("dr_rdcnt", a_rd_count, 0);

      // Random traffic against a unit queue; partial unit B0 is still stored
      q.push_back(32'hB0B0_B0B0);
      for (int c = 0; c < 80; c++) begin
         w_b = ($urandom_range(0, 9) < 6);
         r_b = 1'($urandom_range(0, 1));
         d_saved = $urandom;
         a_wr_en = w_b; a_rd_en = r_b; a_din = d_saved;
         exp_rd = r_b && (q.size() >= 2);
         exp_wr = w_b && (q.size() < 8);
         exp_d  = exp_rd ? {q[1], q[0]} : 64'h0;
         tick;
         if (exp_rd) begin
            void'(q.pop_front());
            void'(q.pop_front());
         end
         if (exp_wr) q.push_back(d_saved);
         chk("rnd_valid", a_valid, exp_rd);
         if (exp_rd) chk("rnd_dout", a_dout, exp_d);
         chk("rnd_wrcnt", a_wr_count, 64'(q.size()));
         $display("rnd %0d wr=%0b rd=%0b dout=%h wr_count=%0d", c, w_b, r_b, a_dout, a_wr_count);
      end
      a_wr_en = 0; a_rd_en = 0;

      // Clean slate, then store 5 words and reset in the middle of a cycle
      rst = 1; #2; rst = 0;
      tick;
      for (int i = 0; i < 7; i++) begin
         a_wr_en = 1; a_din = 32'hC000_0000 + 32'(i);
         tick;
      end
      a_wr_en = 0; a_rd_en = 1;
      tick;
      a_rd_en = 0;
      chk("mr_pre_dout", a_dout, 64'hC000_0001_C000_0000);
      chk("mr_pre_wrcnt", a_wr_count, 5);
      rst = 1;
      #1;
      chk("mr_empty", a_empty, 1);
      chk("mr_wrcnt", a_wr_count, 0);
      chk("mr_rdcnt", a_rd_count, 0);
      chk("mr_valid", a_valid, 0);
      chk("mr_dout", a_dout, 0);
      $display("mid-op reset empty=%0b wr_count=%0d", a_empty, a_wr_count);
      #1;
      rst = 0;
      a_wr_en = 1; a_din = 32'hD000_0000;
      tick;
      a_din = 32'hD000_0001;
      tick;
      a_wr_en = 0; a_rd_en = 1;
      tick;
      a_rd_en = 0;
      chk("post_rst_dout", a_dout, 64'hD000_0001_D000_0000);
      chk("post_rst_empty", a_empty, 1);
      chk("post_rst_wrcnt", a_wr_count, 0);

      // Downsizing FWFT instance
      b_wr_en = 1; b_din = 64'h4444_3333_2222_1111;
      tick;
      b_wr_en = 0;
      chk("b_valid", b_valid, 1);
      chk("b_dout0", b_dout, 16'h1111);
      chk("b_wrcnt", b_wr_count, 1);
      chk("b_rdcnt", b_rd_count, 4);
      b_rd_en = 1;
      tick;
      chk("b_dout1", b_dout, 16'h2222);
      tick;
      chk("b_dout2", b_dout, 16'h3333);
      tick;
      chk("b_dout3", b_dout, 16'h4444);
      tick;
      b_rd_en = 0;
      chk("b_empty", b_empty, 1);
      chk("b_dout_empty", b_dout, 0);
      chk("b_valid_empty", b_valid, 0);
      chk("b_no_uf", b_underflow, 0);
      $display("fwft drained empty=%0b dout=%h", b_empty, b_dout);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
